// File: rtl/adxl362_spi_reader_if.sv
// adxl362_spi_reader_if
// Bundles the ADXL362 SPI pins and the sample outputs handed to the
// player-control logic.
//   sclk, mosi, cs_n : SPI mode 0 pins driven by the master
//   miso             : serial data returned by the accelerometer
//   x_data/y_data/z_data : latest 8-bit two's complement samples
//   data_valid       : one-cycle pulse when the samples update
//   init_done        : high once the configuration write has completed
// master: the reader block. slave: the accelerometer side / consumers.
interface adxl362_spi_reader_if;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;
    logic [7:0] x_data;
    logic [7:0] y_data;
    logic [7:0] z_data;
    logic       data_valid;
    logic       init_done;

    modport master (
        output sclk,
        output mosi,
        output cs_n,
        output x_data,
        output y_data,
        output z_data,
        output data_valid,
        output init_done,
        input  miso
    );

    modport slave (
        input  sclk,
        input  mosi,
        input  cs_n,
        input  x_data,
        input  y_data,
        input  z_data,
        input  data_valid,
        input  init_done,
        output miso
    );
endinterface

// File: rtl/adxl362_spi_reader.sv
// adxl362_spi_reader
// SPI mode-0 master for the ADXL362. After a boot delay it writes
// POWER_CTL=0x02 (measurement mode), then polls XDATA/YDATA/ZDATA with a
// 5-byte burst read every read period and presents the samples with a
// one-cycle data_valid pulse. SCLK is produced from clk by a half-period
// counter, so everything stays in the clk domain.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : adxl362_spi_reader_if.master (SPI pins + sample outputs)
// Parameters:
//   HALF_PERIOD   : clk cycles per SCLK half-period (>= 2)
//   BOOT_DELAY    : clk cycles after reset before the configuration write
//   POLL_INTERVAL : clk cycles cs_n stays high between transactions
module adxl362_spi_reader #(
    parameter int HALF_PERIOD   = 13,
    parameter int BOOT_DELAY    = 500000,
    parameter int POLL_INTERVAL = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    adxl362_spi_reader_if.master        bus
);

    localparam int MAX_DELAY = (BOOT_DELAY > POLL_INTERVAL) ? BOOT_DELAY : POLL_INTERVAL;
    localparam int CNT_W     = $clog2(MAX_DELAY + 1);
    localparam int HP_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int HALF_W    = 7;

    localparam logic [CNT_W-1:0]  BOOT_LAST = CNT_W'(BOOT_DELAY - 1);
    localparam logic [CNT_W-1:0]  POLL_LAST = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [HP_W-1:0]   HP_LAST   = HP_W'(HALF_PERIOD - 1);

    // Half-period index of the final (release) half of an N-byte frame:
    // 16N toggling halves, one idle half with sclk low, then the release half.
    localparam logic [HALF_W-1:0] CFG_END  = HALF_W'(16 * 3 + 1);
    localparam logic [HALF_W-1:0] READ_END = HALF_W'(16 * 5 + 1);

    // Frames are left-aligned in 40 bits; only the first 8N bits are sent.
    localparam logic [39:0] CFG_FRAME  = 40'h0A_2D_02_00_00;
    localparam logic [39:0] READ_FRAME = 40'h0B_08_00_00_00;

    localparam logic [2:0] ST_BOOT = 3'd0;
    localparam logic [2:0] ST_CFG  = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [HP_W-1:0]   hp_reg, hp_next;
    logic [HALF_W-1:0] half_reg, half_next;
    logic              sclk_reg, sclk_next;
    logic              cs_n_reg, cs_n_next;
    logic              mosi_reg, mosi_next;
    logic [38:0]       tx_reg, tx_next;
    logic [23:0]       rx_reg, rx_next;
    logic              init_done_reg, init_done_next;
    logic              data_valid_reg, data_valid_next;

    logic              load_axes;
    logic              start_xfer;
    logic [39:0]       start_frame;
    logic [HALF_W-1:0] end_half;
    logic              hp_tc;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        hp_next         = hp_reg;
        half_next       = half_reg;
        sclk_next       = sclk_reg;
        cs_n_next       = cs_n_reg;
        mosi_next       = mosi_reg;
        tx_next         = tx_reg;
        rx_next         = rx_reg;
        init_done_next  = init_done_reg;
        data_valid_next = 1'b0;
        load_axes       = 1'b0;
        start_xfer      = 1'b0;
        start_frame     = CFG_FRAME;
        hp_tc           = (hp_reg == HP_LAST);
        end_half        = (state_reg == ST_READ) ? READ_END : CFG_END;

        case (state_reg)
            ST_BOOT: begin
                if (cnt_reg == BOOT_LAST) begin
                    start_xfer  = 1'b1;
                    start_frame = CFG_FRAME;
                    state_next  = ST_CFG;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_reg == POLL_LAST) begin
                    start_xfer  = 1'b1;
                    start_frame = READ_FRAME;
                    state_next  = ST_READ;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_CFG, ST_READ: begin
                if (!hp_tc) begin
                    hp_next = hp_reg + 1'b1;
                end else begin
                    hp_next   = '0;
                    half_next = half_reg + 1'b1;
                    if (half_reg == end_half) begin
                        // Release half finished: end the frame.
                        cs_n_next = 1'b1;
                        mosi_next = 1'b0;
                        half_next = '0;
                        cnt_next  = '0;
                        if (state_reg == ST_CFG) begin
                            init_done_next = 1'b1;
                            state_next     = ST_GAP;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else if (half_reg < end_half - 1'b1) begin
                        sclk_next = ~sclk_reg;
                        if (!sclk_reg) begin
                            // Rising edge: the slave has held miso since
                            // its previous falling edge, so sample directly.
                            rx_next = {rx_reg[22:0], bus.miso};
                        end else if (half_reg != end_half - 2'd2) begin
                            // Falling edge, except the final one of the frame.
                            mosi_next = tx_reg[38];
                            tx_next   = {tx_reg[37:0], 1'b0};
                        end
                    end
                    // The half before the release half is idle: sclk stays low.
                end
            end

            ST_DONE: begin
                // rx_reg now holds the bytes from slots 3..5 (X, Y, Z);
                // command/address slots have already been shifted out.
                load_axes       = 1'b1;
                data_valid_next = 1'b1;
                cnt_next        = '0;
                state_next      = ST_GAP;
            end

            default: begin
                state_next = ST_BOOT;
                cnt_next   = '0;
            end
        endcase

        // cs_n falls and bit 7 of byte 0 appears on mosi in the same cycle.
        if (start_xfer) begin
            cs_n_next = 1'b0;
            sclk_next = 1'b0;
            mosi_next = start_frame[39];
            tx_next   = start_frame[38:0];
            hp_next   = '0;
            half_next = '0;
            cnt_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_BOOT;
            cnt_reg        <= '0;
            hp_reg         <= '0;
            half_reg       <= '0;
            sclk_reg       <= 1'b0;
            cs_n_reg       <= 1'b1;
            mosi_reg       <= 1'b0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            init_done_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            hp_reg         <= hp_next;
            half_reg       <= half_next;
            sclk_reg       <= sclk_next;
            cs_n_reg       <= cs_n_next;
            mosi_reg       <= mosi_next;
            tx_reg         <= tx_next;
            rx_reg         <= rx_next;
            init_done_reg  <= init_done_next;
            data_valid_reg <= data_valid_next;
        end
    end

    // One holding register per axis: gi=0 -> X, 1 -> Y, 2 -> Z.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_axis
            logic [7:0] axis_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    axis_reg <= '0;
                end else if (load_axes) begin
                    axis_reg <= rx_reg[23 - 8 * gi -: 8];
                end
            end
        end
    endgenerate

    assign bus.sclk       = sclk_reg;
    assign bus.cs_n       = cs_n_reg;
    assign bus.mosi       = mosi_reg;
    assign bus.x_data     = g_axis[0].axis_reg;
    assign bus.y_data     = g_axis[1].axis_reg;
    assign bus.z_data     = g_axis[2].axis_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.init_done  = init_done_reg;

endmodule

// File: tb/tb_adxl362_spi_reader.sv
// tb_adxl362_spi_reader
// Directed bench for adxl362_spi_reader with a behavioural ADXL362
// (mode 0, burst read). Small parameters keep frames short.
module tb_adxl362_spi_reader;

    localparam int HP     = 2;
    localparam int BD     = 10;
    localparam int PI     = 20;
    localparam int CLK_NS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adxl362_spi_reader_if bus();

    adxl362_spi_reader #(
        .HALF_PERIOD   (HP),
        .BOOT_DELAY    (BD),
        .POLL_INTERVAL (PI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- accelerometer model ----------------
    logic [7:0]  mx = 8'h00, my = 8'h00, mz = 8'h00;
    int          tie_mode = 0;      // 0: data, 1: miso high, 2: miso low
    int          bit_i = 0;
    int          rise_cnt = 0;
    int          sclk_rise_total = 0;
    logic [39:0] mosi_sr = '0;
    bit          in_txn = 1'b0;
    time         t_fall = 0, t_rise = 0, t_dv = 0;
    int          low_cyc = 0, high_cyc = 0, gap_dv_cyc = 0, txn_rises = 0, txn_count = 0;
    logic [39:0] txn_mosi = '0;

    function automatic logic miso_bit(input int i);
        logic [39:0] frame;
        frame = {16'h0000, mx, my, mz};
        if (tie_mode == 1) return 1'b1;
        if (tie_mode == 2) return 1'b0;
        if (i < 40) return frame[39 - i];
        return 1'b0;
    endfunction

    initial bus.miso = 1'b0;

    always @(negedge bus.cs_n) begin
        in_txn     = 1'b1;
        t_fall     = $time;
        high_cyc   = int'((t_fall - t_rise) / CLK_NS);
        gap_dv_cyc = int'((t_fall - t_dv) / CLK_NS);
        rise_cnt   = 0;
        mosi_sr    = '0;
        bit_i      = 0;
        bus.miso   = miso_bit(0);
    end

    always @(posedge bus.sclk) begin
        sclk_rise_total++;
        if (bus.cs_n === 1'b0) begin
            mosi_sr = {mosi_sr[38:0], bus.mosi};
            rise_cnt++;
        end
    end

    always @(negedge bus.sclk) begin
        if (bus.cs_n === 1'b0) begin
            bit_i++;
            bus.miso = miso_bit(bit_i);
        end
    end

    always @(posedge bus.cs_n) begin
        if (in_txn) begin
            in_txn    = 1'b0;
            t_rise    = $time;
            low_cyc   = int'((t_rise - t_fall) / CLK_NS);
            txn_rises = rise_cnt;
            txn_mosi  = mosi_sr;
            txn_count++;
            $display("txn %0d: cs_n low %0d cycles, %0d sclk rises, mosi bits=%010h",
                     txn_count, low_cyc, txn_rises, txn_mosi);
        end
    end

    always @(posedge bus.data_valid) t_dv = $time;

    // ---------------- continuous protocol monitors ----------------
    logic       cs_d1 = 1'b1, cs_d2 = 1'b1, dv_d1 = 1'b0;
    logic [7:0] px = '0, py = '0, pz = '0;
    int         dv_count = 0, dv_align_err = 0, dv_width_err = 0, hold_err = 0, idle_err = 0;
    time        dv_t_prev = 0, dv_t_last = 0;

    always @(negedge clk) begin
        if (bus.cs_n === 1'b1 && bus.sclk !== 1'b0) idle_err++;
        if (!rst) begin
            if (bus.data_valid === 1'b1) begin
                dv_count++;
                dv_t_prev = dv_t_last;
                dv_t_last = $time;
                if (dv_d1 === 1'b1) dv_width_err++;
                if (!(cs_d1 === 1'b1 && cs_d2 === 1'b0)) dv_align_err++;
            end else if ({bus.x_data, bus.y_data, bus.z_data} !== {px, py, pz}) begin
                hold_err++;
            end
        end
        px    = bus.x_data;
        py    = bus.y_data;
        pz    = bus.z_data;
        dv_d1 = bus.data_valid;
        cs_d2 = cs_d1;
        cs_d1 = bus.cs_n;
    end

    // ---------------- helpers ----------------
    task automatic wait_txn(input int target, input string tag);
        int n = 0;
        while (txn_count < target && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check_value(tag, 64'(txn_count >= target), 64'd1);
    endtask

    task automatic wait_dv(input int target, input string tag);
        int n = 0;
        while (dv_count < target && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_value(tag, 64'(dv_count >= target), 64'd1);
    endtask

    // Called right after rst is released; counts clk edges to cs_n falling.
    task automatic boot_wait(input string tag);
        int n = 0;
        int rises0;
        rises0 = sclk_rise_total;
        while (bus.cs_n !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_value({tag, "_cycles"}, 64'(n), 64'(BD));
        check_value({tag, "_no_sclk"}, 64'(sclk_rise_total - rises0), 64'd0);
        check_value({tag, "_init_low"}, 64'(bus.init_done), 64'd0);
    endtask

    logic [23:0] vec [3];

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int dvc;
        vec[0] = 24'h12F37E;
        vec[1] = 24'h010203;
        vec[2] = 24'h807FFF;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_sclk", 64'(bus.sclk), 64'd0);
        check_value("rst_cs_n", 64'(bus.cs_n), 64'd1);
        check_value("rst_mosi", 64'(bus.mosi), 64'd0);
        check_value("rst_xyz", 64'({bus.x_data, bus.y_data, bus.z_data}), 64'd0);
        check_value("rst_dv", 64'(bus.data_valid), 64'd0);
        check_value("rst_init", 64'(bus.init_done), 64'd0);

        {mx, my, mz} = vec[0];
        rst = 1'b0;
        boot_wait("boot");

        // Configuration write
        wait_txn(1, "cfg_done");
        check_value("cfg_mosi", 64'(txn_mosi[23:0]), 64'h0A2D02);
        check_value("cfg_rises", 64'(txn_rises), 64'd24);
        check_value("cfg_low", 64'(low_cyc), 64'd100);
        check_value("cfg_init", 64'(bus.init_done), 64'd1);

        // Periodic reads with changing data
        for (int i = 0; i < 3; i++) begin
            {mx, my, mz} = vec[i];
            wait_txn(2 + i, "read_done");
            if (i == 0) check_value("gap_after_cfg", 64'(high_cyc), 64'(PI));
            else        check_value("gap_after_dv", 64'(gap_dv_cyc), 64'(PI));
            check_value("read_mosi", 64'(txn_mosi), 64'h0B08000000);
            check_value("read_rises", 64'(txn_rises), 64'd40);
            check_value("read_low", 64'(low_cyc), 64'd164);
            wait_dv(i + 1, "dv_seen");
            check_value("dv_high", 64'(bus.data_valid), 64'd1);
            check_value("read_xyz", 64'({bus.x_data, bus.y_data, bus.z_data}), 64'(vec[i]));
            if (i > 0) check_value("dv_period", 64'((dv_t_last - dv_t_prev) / CLK_NS), 64'd185);
            @(negedge clk); #1;
            check_value("dv_pulse_end", 64'(bus.data_valid), 64'd0);
            check_value("read_hold", 64'({bus.x_data, bus.y_data, bus.z_data}), 64'(vec[i]));
            check_value("init_stays", 64'(bus.init_done), 64'd1);
        end

        // Reset during byte 4 of the next read
        {mx, my, mz} = 24'hAA553C;
        begin
            int n = 0;
            while (!(bus.cs_n === 1'b0 && rise_cnt >= 27) && n < 1000) begin
                @(negedge clk); #1;
                n++;
            end
            check_value("midread_reached", 64'(rise_cnt >= 27 && rise_cnt <= 32), 64'd1);
        end
        #2;
        dvc = dv_count;
        rst = 1'b1;
        #1;
        check_value("mid_cs_n", 64'(bus.cs_n), 64'd1);
        check_value("mid_sclk", 64'(bus.sclk), 64'd0);
        check_value("mid_mosi", 64'(bus.mosi), 64'd0);
        check_value("mid_xyz", 64'({bus.x_data, bus.y_data, bus.z_data}), 64'd0);
        check_value("mid_dv", 64'(bus.data_valid), 64'd0);
        check_value("mid_init", 64'(bus.init_done), 64'd0);
        repeat (3) @(negedge clk);
        base = txn_count;
        rst = 1'b0;
        check_value("mid_no_dv", 64'(dv_count), 64'(dvc));
        tie_mode = 1;
        boot_wait("reboot");
        wait_txn(base + 1, "recfg_done");
        check_value("recfg_mosi", 64'(txn_mosi[23:0]), 64'h0A2D02);
        check_value("recfg_rises", 64'(txn_rises), 64'd24);
        check_value("recfg_init", 64'(bus.init_done), 64'd1);

        // MISO tied high
        wait_txn(base + 2, "tie_hi_done");
        wait_dv(dvc + 1, "tie_hi_dv");
        check_value("tie_hi_xyz", 64'({bus.x_data, bus.y_data, bus.z_data}), 64'hFFFFFF);
        @(negedge clk); #1;
        tie_mode = 2;

        // MISO tied low
        wait_txn(base + 3, "tie_lo_done");
        wait_dv(dvc + 2, "tie_lo_dv");
        check_value("tie_lo_xyz", 64'({bus.x_data, bus.y_data, bus.z_data}), 64'h000000);
        check_value("tie_lo_period", 64'((dv_t_last - dv_t_prev) / CLK_NS), 64'd185);
        repeat (3) @(negedge clk);

        check_value("sclk_idle_low", 64'(idle_err), 64'd0);
        check_value("dv_width", 64'(dv_width_err), 64'd0);
        check_value("dv_after_cs", 64'(dv_align_err), 64'd0);
        check_value("xyz_hold", 64'(hold_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
